// File: rtl/sysmem_icb_arb2.sv
// sysmem_icb_arb2 -- two-master ICB arbiter in front of the system-memory port.
//
// One command is granted per cycle and forwarded combinationally to the sysmem
// slave. The issuing master of every accepted command is recorded in a 1-bit ID
// FIFO. Responses come back in order, and the FIFO head steers each one to the
// master that issued it.
//
// Optional feature (compile-time macro SYSMEM_ARB_RR_EN):
//   defined     : round-robin between the masters when both request
//   not defined : fixed priority, m0 always wins when no command is locked
//
// Parameters:
//   AW         command address width
//   OUTS_DEPTH maximum outstanding transactions (power of two, 2..16)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_icb_cmd_* / m1_icb_cmd_* master command channels (valid/ready/addr/read/wdata/wmask)
//   m0_icb_rsp_* / m1_icb_rsp_* master response channels (valid/ready/err/rdata)
//   sysmem_icb_cmd_*           slave command channel
//   sysmem_icb_rsp_*           slave response channel
module sysmem_icb_arb2 #(
  parameter int AW         = 32,
  parameter int OUTS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [31:0]   m0_icb_cmd_wdata,
  input  logic [3:0]    m0_icb_cmd_wmask,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic          m0_icb_rsp_err,
  output logic [31:0]   m0_icb_rsp_rdata,
  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [31:0]   m1_icb_cmd_wdata,
  input  logic [3:0]    m1_icb_cmd_wmask,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic          m1_icb_rsp_err,
  output logic [31:0]   m1_icb_rsp_rdata,
  output logic          sysmem_icb_cmd_valid,
  input  logic          sysmem_icb_cmd_ready,
  output logic [AW-1:0] sysmem_icb_cmd_addr,
  output logic          sysmem_icb_cmd_read,
  output logic [31:0]   sysmem_icb_cmd_wdata,
  output logic [3:0]    sysmem_icb_cmd_wmask,
  input  logic          sysmem_icb_rsp_valid,
  output logic          sysmem_icb_rsp_ready,
  input  logic          sysmem_icb_rsp_err,
  input  logic [31:0]   sysmem_icb_rsp_rdata
);

  localparam int PW = $clog2(OUTS_DEPTH);
  localparam int CW = PW + 1;

  logic                  r_lock_vld;
  logic                  r_lock_id;
  logic [OUTS_DEPTH-1:0] r_fifo;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic w_full;
  logic w_empty;
  logic w_arb_grant;
  logic w_grant;
  logic w_grant_vld;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_count == CW'(OUTS_DEPTH));
  assign w_empty = (r_count == '0);

`ifdef SYSMEM_ARB_RR_EN
  // Master that won the most recent command handshake; reset to m1 so m0 wins first.
  logic r_last_grant;

  always_comb begin
    w_arb_grant = 1'b0;
    if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      w_arb_grant = ~r_last_grant;
    end else if (m1_icb_cmd_valid) begin
      w_arb_grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_push) begin
      r_last_grant <= w_grant;
    end
  end
`else
  assign w_arb_grant = m1_icb_cmd_valid & ~m0_icb_cmd_valid;
`endif

  // A command that was presented but not accepted keeps its grant, so the
  // slave never sees the payload change under a pending valid.
  assign w_grant     = r_lock_vld ? r_lock_id : w_arb_grant;
  assign w_grant_vld = w_grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;

  assign sysmem_icb_cmd_valid = w_grant_vld & ~w_full;
  assign sysmem_icb_cmd_addr  = w_grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign sysmem_icb_cmd_read  = w_grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign sysmem_icb_cmd_wdata = w_grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign sysmem_icb_cmd_wmask = w_grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

  // Full blocks new commands even when a response pops in the same cycle.
  assign m0_icb_cmd_ready = ~w_grant & sysmem_icb_cmd_ready & ~w_full;
  assign m1_icb_cmd_ready =  w_grant & sysmem_icb_cmd_ready & ~w_full;

  assign w_push = sysmem_icb_cmd_valid & sysmem_icb_cmd_ready;

  // The head ID routes the response; an empty FIFO stalls a stray response.
  assign w_head               = r_fifo[r_rptr];
  assign m0_icb_rsp_valid     = sysmem_icb_rsp_valid & ~w_empty & ~w_head;
  assign m1_icb_rsp_valid     = sysmem_icb_rsp_valid & ~w_empty &  w_head;
  assign sysmem_icb_rsp_ready = ~w_empty & (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign m0_icb_rsp_err       = sysmem_icb_rsp_err;
  assign m1_icb_rsp_err       = sysmem_icb_rsp_err;
  assign m0_icb_rsp_rdata     = sysmem_icb_rsp_rdata;
  assign m1_icb_rsp_rdata     = sysmem_icb_rsp_rdata;

  assign w_pop = sysmem_icb_rsp_valid & sysmem_icb_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
    end else if (w_push) begin
      r_lock_vld <= 1'b0;
    end else if (sysmem_icb_cmd_valid && !sysmem_icb_cmd_ready) begin
      r_lock_vld <= 1'b1;
      r_lock_id  <= w_grant;
    end
  end

  // Pointers wrap naturally because OUTS_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_grant;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sysmem_icb_arb2.sv
// Testbench for sysmem_icb_arb2: directed stimulus with a scoreboard. Expected
// slave commands and master responses are queued as stimulus is issued, and a
// monitor pops and compares them whenever a handshake is observed.
module tb_sysmem_icb_arb2;

  typedef struct packed {
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct packed {
    logic src;
    cmd_t c;
  } exp_cmd_t;

  typedef struct packed {
    logic        dst;
    logic        err;
    logic [31:0] rdata;
  } exp_rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;
  logic        sysmem_icb_cmd_valid, sysmem_icb_cmd_ready, sysmem_icb_cmd_read;
  logic [31:0] sysmem_icb_cmd_addr, sysmem_icb_cmd_wdata;
  logic [3:0]  sysmem_icb_cmd_wmask;
  logic        sysmem_icb_rsp_valid, sysmem_icb_rsp_ready, sysmem_icb_rsp_err;
  logic [31:0] sysmem_icb_rsp_rdata;

  logic [140:0] all_out;
  assign all_out = {m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid,
                    m0_icb_rsp_err, m1_icb_rsp_err, m0_icb_rsp_rdata, m1_icb_rsp_rdata,
                    sysmem_icb_cmd_valid, sysmem_icb_cmd_addr, sysmem_icb_cmd_read,
                    sysmem_icb_cmd_wdata, sysmem_icb_cmd_wmask, sysmem_icb_rsp_ready};

  sysmem_icb_arb2 #(.AW(32), .OUTS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .sysmem_icb_cmd_valid(sysmem_icb_cmd_valid), .sysmem_icb_cmd_ready(sysmem_icb_cmd_ready),
    .sysmem_icb_cmd_addr(sysmem_icb_cmd_addr), .sysmem_icb_cmd_read(sysmem_icb_cmd_read),
    .sysmem_icb_cmd_wdata(sysmem_icb_cmd_wdata), .sysmem_icb_cmd_wmask(sysmem_icb_cmd_wmask),
    .sysmem_icb_rsp_valid(sysmem_icb_rsp_valid), .sysmem_icb_rsp_ready(sysmem_icb_rsp_ready),
    .sysmem_icb_rsp_err(sysmem_icb_rsp_err), .sysmem_icb_rsp_rdata(sysmem_icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  int          outst;
  logic [31:0] rsp_seq;
  logic        slv_rdy, m0_rdy_drv, m1_rdy_drv, err_drv;

  cmd_t     m0_list[$];
  cmd_t     m1_list[$];
  exp_cmd_t exp_cmd_q[$];
  exp_rsp_t exp_rsp_q[$];
  exp_cmd_t mon_c;
  exp_rsp_t mon_r;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [31:0] a, input logic r, input logic [31:0] d,
                              input logic [3:0] m);
    cmd_t c;
    c.addr = a; c.read = r; c.wdata = d; c.wmask = m;
    return c;
  endfunction

  task automatic expect_cmd(input logic src, input cmd_t c, input logic [31:0] rdata,
                            input logic err);
    exp_cmd_t ec;
    exp_rsp_t er;
    ec.src = src; ec.c = c;
    er.dst = src; er.err = err; er.rdata = rdata;
    exp_cmd_q.push_back(ec);
    exp_rsp_q.push_back(er);
  endtask

  // All bench-driven inputs change 1 time unit after the rising edge.
  task automatic cycle_drive(input bit rsp_en);
    @(posedge clk);
    #1;
    m0_icb_cmd_valid = (m0_list.size() != 0);
    if (m0_icb_cmd_valid) {m0_icb_cmd_addr, m0_icb_cmd_read, m0_icb_cmd_wdata, m0_icb_cmd_wmask} = m0_list[0];
    else {m0_icb_cmd_addr, m0_icb_cmd_read, m0_icb_cmd_wdata, m0_icb_cmd_wmask} = '0;
    m1_icb_cmd_valid = (m1_list.size() != 0);
    if (m1_icb_cmd_valid) {m1_icb_cmd_addr, m1_icb_cmd_read, m1_icb_cmd_wdata, m1_icb_cmd_wmask} = m1_list[0];
    else {m1_icb_cmd_addr, m1_icb_cmd_read, m1_icb_cmd_wdata, m1_icb_cmd_wmask} = '0;
    sysmem_icb_cmd_ready = slv_rdy;
    m0_icb_rsp_ready     = m0_rdy_drv;
    m1_icb_rsp_ready     = m1_rdy_drv;
    sysmem_icb_rsp_valid = rsp_en && (outst > 0);
    sysmem_icb_rsp_rdata = sysmem_icb_rsp_valid ? rsp_seq : 32'h0;
    sysmem_icb_rsp_err   = sysmem_icb_rsp_valid & err_drv;
  endtask

  task automatic cycle_sample();
    @(negedge clk);
    if (m0_icb_cmd_valid && m0_icb_cmd_ready) begin m0_list.delete(0); outst++; end
    if (m1_icb_cmd_valid && m1_icb_cmd_ready) begin m1_list.delete(0); outst++; end
    if (sysmem_icb_rsp_valid && sysmem_icb_rsp_ready) begin outst--; rsp_seq++; end
  endtask

  task automatic run_all(input bit rsp_en, input string name);
    int guard = 0;
    while ((m0_list.size() != 0 || m1_list.size() != 0 || (rsp_en && outst > 0)) && guard < 60) begin
      cycle_drive(rsp_en);
      cycle_sample();
      guard++;
    end
    chk(name, 160'({m0_list.size(), m1_list.size(), rsp_en ? outst : 0}), 160'(0));
  endtask

  task automatic stray_check(input string name);
    cycle_drive(0);
    sysmem_icb_rsp_valid = 1'b1;
    sysmem_icb_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk(name, 160'({sysmem_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid}), 160'(0));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sysmem_icb_cmd_valid && sysmem_icb_cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cmd_extra: got addr %h, no command expected", sysmem_icb_cmd_addr);
        end else begin
          mon_c = exp_cmd_q.pop_front();
          chk("cmd", 160'({m1_icb_cmd_ready, m0_icb_cmd_ready, sysmem_icb_cmd_addr, sysmem_icb_cmd_read,
                           sysmem_icb_cmd_wdata, sysmem_icb_cmd_wmask}),
              160'({mon_c.src, ~mon_c.src, mon_c.c}));
        end
      end
      if (m0_icb_rsp_valid && m1_icb_rsp_valid) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_both: got both rsp_valid, expected one");
      end
      if ((m0_icb_rsp_valid && m0_icb_rsp_ready) || (m1_icb_rsp_valid && m1_icb_rsp_ready)) begin
        if (exp_rsp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_extra: got rdata %h, no response expected", sysmem_icb_rsp_rdata);
        end else begin
          mon_r = exp_rsp_q.pop_front();
          if (m1_icb_rsp_valid)
            chk("rsp_m1", 160'({1'b1, m1_icb_rsp_err, m1_icb_rsp_rdata}), 160'(mon_r));
          else
            chk("rsp_m0", 160'({1'b0, m0_icb_rsp_err, m0_icb_rsp_rdata}), 160'(mon_r));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t a[4];
    cmd_t b[2];
    cmd_t c;
    cmd_t c1;
    n_tests = 0; n_fail = 0; outst = 0; rsp_seq = 0;
    slv_rdy = 0; m0_rdy_drv = 1; m1_rdy_drv = 1; err_drv = 0;
    rst_n = 0;
    m0_icb_cmd_valid = 0; m0_icb_cmd_addr = 0; m0_icb_cmd_read = 0; m0_icb_cmd_wdata = 0; m0_icb_cmd_wmask = 0;
    m1_icb_cmd_valid = 0; m1_icb_cmd_addr = 0; m1_icb_cmd_read = 0; m1_icb_cmd_wdata = 0; m1_icb_cmd_wmask = 0;
    m0_icb_rsp_ready = 0; m1_icb_rsp_ready = 0; sysmem_icb_cmd_ready = 0;
    sysmem_icb_rsp_valid = 0; sysmem_icb_rsp_err = 0; sysmem_icb_rsp_rdata = 0;

    // Reset state: all outputs 0 with all inputs 0.
    @(negedge clk);
    chk("reset_outputs", 160'(all_out), 160'(0));
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("idle_outputs", 160'(all_out), 160'(0));

    // Single read from m0.
    slv_rdy = 1; rsp_seq = 32'hDEAD_BEEF;
    c = mk(32'h8000_0000, 1'b1, 32'h0, 4'h0);
    m0_list.push_back(c);
    expect_cmd(1'b0, c, 32'hDEAD_BEEF, 1'b0);
    cycle_drive(0); cycle_sample();
    chk("t1_cmd_ready", 160'({m0_icb_cmd_ready, m1_icb_cmd_ready}), 160'(2'b10));
    cycle_drive(1); cycle_sample();
    chk("t1_rsp_route", 160'({m0_icb_rsp_valid, m1_icb_rsp_valid, sysmem_icb_rsp_ready}), 160'(3'b101));
    stray_check("t1_count_zero");

    // Both masters requesting, slave always ready, FIFO fills at 4.
    rsp_seq = 32'h100;
    for (int i = 0; i < 4; i++) begin
      a[i] = mk(32'h1000 + 32'(4 * i), 1'b0, 32'hA0 + 32'(i), 4'hF);
      m0_list.push_back(a[i]);
    end
    for (int i = 0; i < 2; i++) begin
      b[i] = mk(32'h2000 + 32'(4 * i), 1'b1, 32'h0, 4'h0);
      m1_list.push_back(b[i]);
    end
`ifdef SYSMEM_ARB_RR_EN
    // Last winner was m0 (single read), so m1 goes first, then alternation.
    expect_cmd(1'b1, b[0], 32'h100, 1'b0);
    expect_cmd(1'b0, a[0], 32'h101, 1'b0);
    expect_cmd(1'b1, b[1], 32'h102, 1'b0);
    expect_cmd(1'b0, a[1], 32'h103, 1'b0);
    expect_cmd(1'b0, a[2], 32'h104, 1'b0);
    expect_cmd(1'b0, a[3], 32'h105, 1'b0);
`else
    expect_cmd(1'b0, a[0], 32'h100, 1'b0);
    expect_cmd(1'b0, a[1], 32'h101, 1'b0);
    expect_cmd(1'b0, a[2], 32'h102, 1'b0);
    expect_cmd(1'b0, a[3], 32'h103, 1'b0);
    expect_cmd(1'b1, b[0], 32'h104, 1'b0);
    expect_cmd(1'b1, b[1], 32'h105, 1'b0);
`endif
    repeat (4) begin cycle_drive(0); cycle_sample(); end
    cycle_drive(0); cycle_sample();
    chk("t2_full_block", 160'({sysmem_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready}), 160'(0));
    cycle_drive(1); cycle_sample();
    chk("t2_full_with_pop", 160'({sysmem_icb_cmd_valid, sysmem_icb_rsp_ready}), 160'(2'b01));
    cycle_drive(1); cycle_sample();
    chk("t2_accept_after_pop", 160'({sysmem_icb_cmd_valid, sysmem_icb_cmd_ready}), 160'(2'b11));
    run_all(1, "t2_drain");

    // Lock: m1 presented while slave stalls, m0 arrives later.
    rsp_seq = 32'h200; slv_rdy = 0;
    c  = mk(32'h3000, 1'b0, 32'h55, 4'h3);
    c1 = mk(32'h4000, 1'b1, 32'h0, 4'h0);
    m1_list.push_back(c);
    expect_cmd(1'b1, c, 32'h200, 1'b0);
    expect_cmd(1'b0, c1, 32'h201, 1'b0);
    cycle_drive(0); cycle_sample();
    chk("t3_present", 160'({sysmem_icb_cmd_valid, sysmem_icb_cmd_addr}), 160'({1'b1, 32'h3000}));
    m0_list.push_back(c1);
    repeat (2) begin
      cycle_drive(0); cycle_sample();
      chk("t3_locked", 160'({m0_icb_cmd_ready, m1_icb_cmd_ready, sysmem_icb_cmd_valid, sysmem_icb_cmd_addr}),
          160'({3'b001, 32'h3000}));
    end
    slv_rdy = 1;
    cycle_drive(0); cycle_sample();
    chk("t3_m1_accept", 160'({m0_icb_cmd_ready, m1_icb_cmd_ready}), 160'(2'b01));
    run_all(1, "t3_drain");

    // Interleaved m0,m1,m0 with m1 stalling its response for 2 cycles.
    rsp_seq = 32'd1;
    c = mk(32'h5000, 1'b1, 32'h0, 4'h0);
    m0_list.push_back(c); expect_cmd(1'b0, c, 32'd1, 1'b0); run_all(0, "t4_cmd0");
    c = mk(32'h5004, 1'b1, 32'h0, 4'h0);
    m1_list.push_back(c); expect_cmd(1'b1, c, 32'd2, 1'b1); run_all(0, "t4_cmd1");
    c = mk(32'h5008, 1'b1, 32'h0, 4'h0);
    m0_list.push_back(c); expect_cmd(1'b0, c, 32'd3, 1'b0); run_all(0, "t4_cmd2");
    cycle_drive(1); cycle_sample();
    m1_rdy_drv = 0; err_drv = 1;
    repeat (2) begin
      cycle_drive(1); cycle_sample();
      chk("t4_stall", 160'({m0_icb_rsp_valid, m1_icb_rsp_valid, sysmem_icb_rsp_ready, m0_icb_rsp_err,
                            m1_icb_rsp_rdata}), 160'({4'b0101, 32'd2}));
    end
    m1_rdy_drv = 1;
    cycle_drive(1); cycle_sample();
    chk("t4_m1_take", 160'(sysmem_icb_rsp_ready), 160'(1));
    err_drv = 0;
    cycle_drive(1); cycle_sample();
    chk("t4_all_done", 160'(outst), 160'(0));

    // Reset with 2 outstanding.
    c  = mk(32'h6000, 1'b1, 32'h0, 4'h0);
    c1 = mk(32'h6004, 1'b1, 32'h0, 4'h0);
    m0_list.push_back(c); m0_list.push_back(c1);
    expect_cmd(1'b0, c, 32'h0, 1'b0); expect_cmd(1'b0, c1, 32'h0, 1'b0);
    run_all(0, "t5_cmds");
    @(posedge clk); #1;
    rst_n = 0;
    m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0; sysmem_icb_cmd_ready = 0;
    m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
    sysmem_icb_rsp_valid = 1; sysmem_icb_rsp_rdata = 32'h77;
    @(negedge clk);
    chk("t5_reset_clear", 160'({sysmem_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid, sysmem_icb_cmd_valid,
                                m0_icb_cmd_ready, m1_icb_cmd_ready}), 160'(0));
    exp_rsp_q.delete();
    outst = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t5_stray_after", 160'({sysmem_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid}), 160'(0));

    // After reset m0 wins the first tie in either arbitration mode.
    rsp_seq = 32'h300; slv_rdy = 1;
    c  = mk(32'h7000, 1'b0, 32'h11, 4'h1);
    c1 = mk(32'h7100, 1'b0, 32'h22, 4'h2);
    m0_list.push_back(c); m1_list.push_back(c1);
    expect_cmd(1'b0, c, 32'h300, 1'b0);
    expect_cmd(1'b1, c1, 32'h301, 1'b0);
    cycle_drive(1); cycle_sample();
    chk("t5_first_m0", 160'({m0_icb_cmd_ready, m1_icb_cmd_ready}), 160'(2'b10));
    run_all(1, "t5_drain");

    cycle_drive(0); cycle_sample();
    chk("exp_cmd_empty", 160'(exp_cmd_q.size()), 160'(0));
    chk("exp_rsp_empty", 160'(exp_rsp_q.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
